logic_op_sequencer: RTL
=======================

Name: logic_op_sequencer

Overview:
- Initiator/driver for the CPU logic unit.
- Accepts logic-operation requests over a valid/ready channel and drives operands and opcode onto the logic unit's input bus.
- Waits a fixed settle time, captures the unit's result and compare flags, then returns them over a valid/ready response channel.
- Sits between the CPU control path and the logic unit; the sole owner of the logic unit inputs.

Parameters:
SETTLE_CYCLES, 1, cycles operands are held on the logic unit before capture (legal range 1..15)
CNT_WIDTH, 16, width of completed-operation counter
(DATA_WIDTH and enum_alu_opcode_t come from CPU_package)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_a  input  DATA_WIDTH  operand A
req_b  input  DATA_WIDTH  operand B
req_op  input  enum_alu_opcode_t  requested opcode
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_result  output  DATA_WIDTH  logic result (0 for CPR or error)
resp_flag  output  3  compare flags: 100 equal, 010 A>B, 001 A<B; 000 for non-CPR
resp_err  output  1  opcode not in the logic set; no operation issued
lu_in_a  output  DATA_WIDTH  to logic unit in_a
lu_in_b  output  DATA_WIDTH  to logic unit in_b
lu_opcode  output  enum_alu_opcode_t  to logic unit alu_opcode
lu_out  input  DATA_WIDTH  from logic unit logic_out
lu_flag  input  3  from logic unit logic_out_flag
busy  output  1  high in every state except IDLE
op_count  output  CNT_WIDTH  count of completed response handshakes, wraps at 2^CNT_WIDTH

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_flag=000, resp_err=0, lu_in_a=0, lu_in_b=0, lu_opcode=ALU_OP_AND, busy=0, op_count=0, settle counter=0.
- Logic set: CPR, AND, OR, XOR, NOT. Every other opcode is illegal.
- All outputs are registered; req_ready = (state==IDLE); resp_valid = (state==RESP).
- Reset mid-operation returns to IDLE. Any pending response is discarded and op_count clears.

States:
- IDLE:
  - On req_valid & req_ready, latch a, b and op.
  - Legal op: load lu_in_a/lu_in_b/lu_opcode, set settle counter = SETTLE_CYCLES-1, go DRIVE.
  - Illegal op: leave lu_* unchanged, set resp_err=1, resp_result=0, resp_flag=000, go RESP.
- DRIVE:
  - lu_* stable for exactly SETTLE_CYCLES cycles.
  - Counter nonzero: decrement.
  - Counter zero: capture into resp registers and go RESP.
  - Capture for CPR: resp_flag=lu_flag, resp_result=0.
  - Capture for AND/OR/XOR/NOT: resp_result=lu_out, resp_flag=000.
  - resp_err=0 on every capture.
- RESP:
  - resp_* held stable while resp_valid & !resp_ready.
  - On resp_ready: go IDLE, op_count+1 (error responses also count).

Timing:
- Request accepted at edge T.
  - Legal op: resp_valid first high in cycle T+1+SETTLE_CYCLES.
  - Illegal op: resp_valid high in cycle T+1.
- One mandatory IDLE cycle between a response handshake and the next request accept. req_ready has no combinational path from resp_ready.
- lu_* keep their last values in IDLE/RESP. The logic unit is always combinational w.r.t. these inputs.
- req_a/req_b/req_op are ignored when req_ready=0.
- op_count wrap: 0xFFFF + 1 -> 0x0000 for CNT_WIDTH=16.

Test Plan:
- Reset, then AND with a=8'hF0, b=8'h3C, SETTLE_CYCLES=1, resp_ready=1 -> resp_valid in cycle T+2; resp_result=8'h30, resp_flag=000, resp_err=0, op_count=1.
- CPR with a=5, b=9, then a=9, b=5, then a=7, b=7 -> resp_flag 001, 010, 100 respectively; resp_result=0 each time; op_count=3.
- NOT a=8'hA5 with resp_ready held low 5 cycles -> resp_valid and resp_result=8'h5A stable all 5 cycles; req_ready=0 throughout; one handshake only when resp_ready rises.
- Illegal opcode (e.g. arithmetic op) -> resp_err=1 in cycle T+1, resp_result=0, resp_flag=000; lu_opcode unchanged; op_count increments.
- SETTLE_CYCLES=4, XOR a=8'hFF, b=8'h0F -> lu_* stable 4 cycles; resp_valid at T+5 with 8'hF0.
- rst asserted during DRIVE and again during RESP -> next cycle IDLE, resp_valid=0, lu_opcode=ALU_OP_AND, op_count=0; preload op_count=16'hFFFF then complete one op -> 16'h0000.

Source files
------------

// File: rtl/CPU_package.sv
// Shared CPU definitions: datapath width and the ALU opcode set.
package CPU_package;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [3:0] {
        ALU_OP_ADD = 4'd0,
        ALU_OP_SUB = 4'd1,
        ALU_OP_AND = 4'd2,
        ALU_OP_OR  = 4'd3,
        ALU_OP_XOR = 4'd4,
        ALU_OP_NOT = 4'd5,
        ALU_OP_CPR = 4'd6,
        ALU_OP_SHL = 4'd7,
        ALU_OP_SHR = 4'd8
    } enum_alu_opcode_t;

endpackage

// File: rtl/logic_op_sequencer.sv
// Sequencer that owns the logic unit inputs: accepts a request, drives the unit,
// waits a settle time, captures result/flags and returns them on a response channel.
//
// state | meaning
// IDLE  | ready for a request; lu_* hold their last values
// DRIVE | operands on the logic unit, settle counter running down
// RESP  | captured response presented until the consumer takes it
module logic_op_sequencer
    import CPU_package::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  enum_alu_opcode_t      req_op,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic [2:0]            resp_flag,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] lu_in_a,
    output logic [DATA_WIDTH-1:0] lu_in_b,
    output enum_alu_opcode_t      lu_opcode,
    input  logic [DATA_WIDTH-1:0] lu_out,
    input  logic [2:0]            lu_flag,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  op_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            settle_cnt_q, settle_cnt_d;
    logic [DATA_WIDTH-1:0] lu_in_a_q, lu_in_a_d;
    logic [DATA_WIDTH-1:0] lu_in_b_q, lu_in_b_d;
    enum_alu_opcode_t      lu_opcode_q, lu_opcode_d;
    logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
    logic [2:0]            resp_flag_q, resp_flag_d;
    logic                  resp_err_q, resp_err_d;
    logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;

    function automatic logic is_logic_op(enum_alu_opcode_t op);
        case (op)
            ALU_OP_CPR, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        lu_in_a_d     = lu_in_a_q;
        lu_in_b_d     = lu_in_b_q;
        lu_opcode_d   = lu_opcode_q;
        resp_result_d = resp_result_q;
        resp_flag_d   = resp_flag_q;
        resp_err_d    = resp_err_q;
        op_count_d    = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_logic_op(req_op)) begin
                        lu_in_a_d    = req_a;
                        lu_in_b_d    = req_b;
                        lu_opcode_d  = req_op;
                        settle_cnt_d = SETTLE_LOAD;
                        state_d      = ST_DRIVE;
                    end else begin
                        // Illegal opcode never reaches the logic unit.
                        resp_err_d    = 1'b1;
                        resp_result_d = '0;
                        resp_flag_d   = 3'b000;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_DRIVE: begin
                if (settle_cnt_q != 4'd0) begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end else begin
                    if (lu_opcode_q == ALU_OP_CPR) begin
                        resp_result_d = '0;
                        resp_flag_d   = lu_flag;
                    end else begin
                        resp_result_d = lu_out;
                        resp_flag_d   = 3'b000;
                    end
                    resp_err_d = 1'b0;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    op_count_d = op_count_q + CNT_WIDTH'(1);
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            settle_cnt_q  <= 4'd0;
            lu_in_a_q     <= '0;
            lu_in_b_q     <= '0;
            lu_opcode_q   <= ALU_OP_AND;
            resp_result_q <= '0;
            resp_flag_q   <= 3'b000;
            resp_err_q    <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            lu_in_a_q     <= lu_in_a_d;
            lu_in_b_q     <= lu_in_b_d;
            lu_opcode_q   <= lu_opcode_d;
            resp_result_q <= resp_result_d;
            resp_flag_q   <= resp_flag_d;
            resp_err_q    <= resp_err_d;
            op_count_q    <= op_count_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = (state_q == ST_RESP);
    assign busy        = (state_q != ST_IDLE);
    assign resp_result = resp_result_q;
    assign resp_flag   = resp_flag_q;
    assign resp_err    = resp_err_q;
    assign lu_in_a     = lu_in_a_q;
    assign lu_in_b     = lu_in_b_q;
    assign lu_opcode   = lu_opcode_q;
    assign op_count    = op_count_q;

endmodule
